memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline stage between execute and `write_back`. It takes one executed instruction at a time, performs the data-memory access for loads and stores through a valid/ready request and response interface, and extracts and sign- or zero-extends load data. It then presents the ALU result, the loaded data, the opcode and the destination register to `write_back`, with a one-cycle `write_back_enable` pulse per instruction. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters: none (RV32, 32-bit data, 4-byte word memory).

Ports (synchronous, active-high reset; one clock):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute has an instruction
- in_ready  out  1  stage can accept (IDLE only)
- alu_result  in  32  ALU result; byte address for loads/stores
- store_data  in  32  rs2 value for stores
- opcode  in  7  instruction opcode
- funct3  in  3  access size/sign
- dest_reg  in  5  rd
- mem_req_valid  out  1  memory request pending
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_we  out  1  1 = store
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (0 for loads)
- mem_resp_valid  in  1  response/ack valid (loads and stores)
- mem_resp_data  in  32  raw read word
- alu_result_out  out  32  registered alu_result
- loaded_data  out  32  extended load value, else 0
- opcode_out  out  7  registered opcode
- dest_reg_out  out  5  registered rd
- write_back_enable  out  1  one-cycle pulse: outputs valid for write_back
- misaligned_fault  out  1  one-cycle pulse: bad access, instruction dropped

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: IDLE, all outputs 0, in_ready=1.
- IDLE: in_ready=1. On in_valid, capture the inputs.
  - Loads (0000011) and stores (0100011) that are legal go to REQ.
  - All other opcodes go to DONE with loaded_data=0.
  - Faults go to DONE with the fault flag set and no memory request issued.
- Fault conditions:
  - funct3 ∈ {011, 110, 111} on a load or store.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- REQ: mem_req_valid=1, with address, we, wdata and wstrb held stable until mem_req_ready. Handshake completes when valid && ready; then go to WAIT. mem_resp_valid is ignored in REQ.
- WAIT: wait for mem_resp_valid.
  - Loads capture the extended data into loaded_data.
  - Stores just acknowledge.
  - Then go to DONE.
- DONE: assert write_back_enable for 1 cycle, or misaligned_fault instead for faults (write_back_enable=0). Return to IDLE.
- Load extraction, with lane = addr[1:0]:
  - LB (000): sign-extend byte[lane].
  - LBU (100): zero-extend byte[lane].
  - LH (001): sign-extend half[addr[1]].
  - LHU (101): zero-extend half[addr[1]].
  - LW (010): full word.
- Store encoding:
  - SB: wstrb = 0001 << lane; wdata = {4{byte}}.
  - SH: wstrb = 0011 << (2·addr[1]); wdata = {2{half}}.
  - SW: wstrb = 1111; wdata = store_data.
- Registered outputs (alu_result_out, opcode_out, dest_reg_out, loaded_data) hold their values after DONE until the next DONE.

## Timing
- Accept in cycle T.
  - Non-memory instruction: write_back_enable in T+1.
  - Fault: misaligned_fault in T+1.
- Memory op, accepted in cycle T:
  - mem_req_valid from T+1.
  - If mem_req_ready is high in T+1, the earliest response is T+2, and write_back_enable is T+3.
  - Each stall cycle on mem_req_ready or mem_resp_valid adds one cycle.
- Throughput: at most one instruction in flight. in_ready=0 in REQ, WAIT and DONE, so the next accept is no earlier than the cycle after DONE.
- Memory handshake rules:
  - mem_resp_valid outside WAIT (including IDLE) is ignored.
  - Exactly one response is expected per accepted request.
- Reset mid-operation: the next cycle is IDLE.
  - mem_req_valid drops.
  - Pulses are not asserted.
  - Any later stray response is ignored.

## Test plan
- ADD-type passthrough: opcode=0110011, alu_result=0x0000_1234, dest_reg=5 -> next cycle write_back_enable=1, alu_result_out=0x1234, dest_reg_out=5, loaded_data=0, no mem_req_valid.
- LB sign-extension: alu_result=0x103, funct3=000, mem_resp_data=0x80FF_0000, mem_req_ready and mem_resp_valid high immediately -> mem_addr=0x100, mem_wstrb=0; loaded_data=0xFFFF_FF80; write_back_enable exactly 3 cycles after accept.
- SH lane and stalls: alu_result=0x202, store_data=0xAAAA_BEEF, funct3=001, mem_req_ready low for 3 cycles -> request held stable with mem_wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_we=1; write_back_enable only after mem_resp_valid.
- Misaligned LW: alu_result=0x101, funct3=010 -> no mem_req_valid; misaligned_fault pulses in T+1 with write_back_enable=0. The same fault occurs for LH at 0x101 and for funct3=011.
- Reset in WAIT: issue LW, assert reset while awaiting the response, then pulse mem_resp_valid -> all outputs 0, in_ready=1, no write_back_enable.
- Back-to-back: in_valid held high with LW followed by ADD -> in_ready low until after DONE; the ADD is accepted in the cycle after the LW's write_back_enable, with no overlap of pulses.

Source files
------------

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, extends
// load data and hands results to write_back with a single-cycle enable pulse.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  dest_reg,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] alu_result_out,
  output logic [31:0] loaded_data,
  output logic [6:0]  opcode_out,
  output logic [4:0]  dest_reg_out,
  output logic        write_back_enable,
  output logic        misaligned_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] reqAddr_q, reqWdata_q;
  logic [3:0]  reqWstrb_q;
  logic        reqWe_q, isLoad_q, fault_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] pendAlu_q, aluOut_q, loaded_q;
  logic [6:0]  pendOpc_q, opcOut_q;
  logic [4:0]  pendDest_q, destOut_q;

  logic        isLoad, isStore, isMem, accessFault, goMemory, accept;
  logic [3:0]  storeStrb;
  logic [31:0] storeWdata, loadExt;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign isLoad  = (opcode == OP_LOAD);
  assign isStore = (opcode == OP_STORE);
  assign isMem   = isLoad || isStore;

  // funct3[1:0] gives the access size; alignment is checked against that size.
  assign accessFault = isMem && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                                 ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                                 ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
  assign goMemory = isMem && !accessFault;
  assign accept   = (state_q == IDLE) && in_valid;

  always_comb begin
    storeStrb  = 4'b1111;
    storeWdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        storeStrb  = 4'b0001 << alu_result[1:0];
        storeWdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        storeStrb  = 4'b0011 << {alu_result[1], 1'b0};
        storeWdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign loadByte = 8'(mem_resp_data >> {lane_q, 3'b000});
  assign loadHalf = lane_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];

  always_comb begin
    loadExt = mem_resp_data;
    case (funct3_q)
      3'b000:  loadExt = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadExt = {24'b0, loadByte};
      3'b001:  loadExt = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadExt = {16'b0, loadHalf};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = goMemory ? REQ : DONE;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_resp_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers only change on the way into DONE so write_back sees stable data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      reqAddr_q  <= '0;
      reqWdata_q <= '0;
      reqWstrb_q <= '0;
      reqWe_q    <= 1'b0;
      isLoad_q   <= 1'b0;
      fault_q    <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      pendAlu_q  <= '0;
      pendOpc_q  <= '0;
      pendDest_q <= '0;
      aluOut_q   <= '0;
      loaded_q   <= '0;
      opcOut_q   <= '0;
      destOut_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        reqAddr_q  <= {alu_result[31:2], 2'b00};
        reqWe_q    <= isStore;
        reqWstrb_q <= isStore ? storeStrb : 4'b0000;
        reqWdata_q <= isStore ? storeWdata : 32'b0;
        isLoad_q   <= isLoad;
        fault_q    <= accessFault;
        funct3_q   <= funct3;
        lane_q     <= alu_result[1:0];
        pendAlu_q  <= alu_result;
        pendOpc_q  <= opcode;
        pendDest_q <= dest_reg;
        if (!goMemory) begin
          aluOut_q  <= alu_result;
          opcOut_q  <= opcode;
          destOut_q <= dest_reg;
          loaded_q  <= 32'b0;
        end
      end
      if ((state_q == WAIT) && mem_resp_valid) begin
        aluOut_q  <= pendAlu_q;
        opcOut_q  <= pendOpc_q;
        destOut_q <= pendDest_q;
        loaded_q  <= isLoad_q ? loadExt : 32'b0;
      end
    end
  end

  assign in_ready          = (state_q == IDLE);
  assign mem_req_valid     = (state_q == REQ);
  assign mem_addr          = mem_req_valid ? reqAddr_q : 32'b0;
  assign mem_we            = mem_req_valid && reqWe_q;
  assign mem_wdata         = mem_req_valid ? reqWdata_q : 32'b0;
  assign mem_wstrb         = mem_req_valid ? reqWstrb_q : 4'b0000;
  assign write_back_enable = (state_q == DONE) && !fault_q;
  assign misaligned_fault  = (state_q == DONE) && fault_q;
  assign alu_result_out    = aluOut_q;
  assign loaded_data       = loaded_q;
  assign opcode_out        = opcOut_q;
  assign dest_reg_out      = destOut_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: drives instructions with random memory
// stalls and checks every cycle against an arithmetic model of each access.
module tb_memory_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [31:0] alu_result, store_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  dest_reg;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_resp_data;
  logic [3:0]  mem_wstrb;
  logic [31:0] alu_result_out, loaded_data;
  logic [6:0]  opcode_out;
  logic [4:0]  dest_reg_out;
  logic        write_back_enable, misaligned_fault;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic checkEn = 1'b0;

  logic        expReady, expReq, expWb, expFault, expWe;
  logic [31:0] expAddr, expWdata, expAlu, expLoaded;
  logic [3:0]  expWstrb;
  logic [6:0]  expOpc;
  logic [4:0]  expDest;

  logic [31:0] seenAddr, seenWdata;
  logic [3:0]  seenWstrb;
  logic        seenWe;
  int lastWbCyc = -100;
  int lastFaultCyc = -100;
  int lastAcceptCyc = 0;

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .opcode(opcode),
    .funct3(funct3), .dest_reg(dest_reg), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .alu_result_out(alu_result_out),
    .loaded_data(loaded_data), .opcode_out(opcode_out), .dest_reg_out(dest_reg_out),
    .write_back_enable(write_back_enable), .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of a single access, written from the size/lane arithmetic rather than per-case tables.
  function automatic logic isMemOp(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic modelFault(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    if (!isMemOp(op)) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 2'b00) return {24'b0, sd[7:0]} * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return {16'b0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
    int nb;
    logic [31:0] mask, val;
    nb = 1 << f3[1:0];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    val = (raw >> (8 * a[1:0])) & mask;
    if (!f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    return val;
  endfunction

  // Per-cycle compare against the expectations the driver maintains.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
      checkOutput("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, expReq});
      checkOutput("write_back_enable", {31'b0, write_back_enable}, {31'b0, expWb});
      checkOutput("misaligned_fault", {31'b0, misaligned_fault}, {31'b0, expFault});
      checkOutput("alu_result_out", alu_result_out, expAlu);
      checkOutput("loaded_data", loaded_data, expLoaded);
      checkOutput("opcode_out", {25'b0, opcode_out}, {25'b0, expOpc});
      checkOutput("dest_reg_out", {27'b0, dest_reg_out}, {27'b0, expDest});
      if (expReq) begin
        checkOutput("mem_addr", mem_addr, expAddr);
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, expWe});
        checkOutput("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, expWstrb});
        if (expWe) checkOutput("mem_wdata", mem_wdata, expWdata);
      end
      if (mem_req_valid) begin
        seenAddr  = mem_addr;
        seenWdata = mem_wdata;
        seenWstrb = mem_wstrb;
        seenWe    = mem_we;
      end
      if (write_back_enable) lastWbCyc = cyc;
      if (misaligned_fault) lastFaultCyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveGarbage();
    in_valid      = 1'($urandom_range(0, 1));
    opcode        = 7'($urandom);
    funct3        = 3'($urandom);
    alu_result    = $urandom;
    store_data    = $urandom;
    dest_reg      = 5'($urandom);
    mem_resp_data = $urandom;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] rd, input int reqStall,
                               input int respStall, input logic [31:0] raw);
    logic flt;
    flt = modelFault(op, f3, alu);
    in_valid = 1'b1; opcode = op; funct3 = f3; alu_result = alu; store_data = sd; dest_reg = rd;
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data = $urandom;
    expReady = 1'b1; expReq = 1'b0; expWb = 1'b0; expFault = 1'b0;
    lastAcceptCyc = cyc;
    step();
    expReady = 1'b0;
    if (!isMemOp(op) || flt) begin
      driveGarbage();
      expWb = !flt; expFault = flt;
      expAlu = alu; expOpc = op; expDest = rd; expLoaded = 32'b0;
      step();
    end else begin
      expReq   = 1'b1;
      expAddr  = {alu[31:2], 2'b00};
      expWe    = (op == OP_STORE);
      expWstrb = expWe ? modelStrb(f3, alu) : 4'b0000;
      expWdata = modelWdata(f3, sd);
      for (int i = 0; i <= reqStall; i++) begin
        driveGarbage();
        mem_req_ready  = (i == reqStall);
        mem_resp_valid = 1'($urandom_range(0, 1));
        step();
      end
      expReq = 1'b0;
      for (int i = 0; i <= respStall; i++) begin
        driveGarbage();
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_valid = (i == respStall);
        if (i == respStall) mem_resp_data = raw;
        step();
      end
      driveGarbage();
      mem_resp_valid = 1'($urandom_range(0, 1));
      expWb = 1'b1;
      expAlu = alu; expOpc = op; expDest = rd;
      expLoaded = (op == OP_LOAD) ? modelLoad(f3, alu, raw) : 32'b0;
      step();
    end
    in_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    expWb = 1'b0; expFault = 1'b0; expReady = 1'b1; expReq = 1'b0;
  endtask

  task automatic resetInWait(input logic [31:0] alu);
    in_valid = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; alu_result = alu; dest_reg = 5'd9;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    expReady = 1'b1; expReq = 1'b0;
    step();
    driveGarbage();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    expReady = 1'b0; expReq = 1'b1; expAddr = {alu[31:2], 2'b00}; expWe = 1'b0; expWstrb = 4'b0000;
    step();
    driveGarbage();
    reset = 1'b1; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    expReq = 1'b0;
    step();
    reset = 1'b0; in_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    expReady = 1'b1; expAlu = '0; expLoaded = '0; expOpc = '0; expDest = '0;
    step();
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    mem_resp_valid = 1'b0;
    step();
  endtask

  initial begin
    int wbBefore;
    logic [6:0] op;
    reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0; opcode = '0;
    funct3 = '0; dest_reg = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    expReady = 1'b1; expReq = 1'b0; expWb = 1'b0; expFault = 1'b0; expWe = 1'b0;
    expAddr = '0; expWdata = '0; expWstrb = '0; expAlu = '0; expLoaded = '0; expOpc = '0; expDest = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkEn = 1'b1;
    step();
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(OP_ADD, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
    checkOutput("add_alu_literal", alu_result_out, 32'h0000_1234);
    checkOutput("add_dest_literal", {27'b0, dest_reg_out}, 32'd5);
    checkOutput("add_latency", lastWbCyc - lastAcceptCyc, 32'd1);

    applyStimulus(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
    checkOutput("lb_addr_literal", seenAddr, 32'h0000_0100);
    checkOutput("lb_wstrb_literal", {28'b0, seenWstrb}, 32'h0);
    checkOutput("lb_data_literal", loaded_data, 32'hFFFF_FF80);
    checkOutput("lb_latency", lastWbCyc - lastAcceptCyc, 32'd3);

    applyStimulus(OP_STORE, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 3, 1, 32'h0);
    checkOutput("sh_wstrb_literal", {28'b0, seenWstrb}, 32'hC);
    checkOutput("sh_wdata_literal", seenWdata, 32'hBEEF_BEEF);
    checkOutput("sh_we_literal", {31'b0, seenWe}, 32'd1);
    checkOutput("sh_latency", lastWbCyc - lastAcceptCyc, 32'd7);

    applyStimulus(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 0, 0, 32'h0);
    checkOutput("lw_misalign_latency", lastFaultCyc - lastAcceptCyc, 32'd1);
    applyStimulus(OP_LOAD, 3'b001, 32'h0000_0101, 32'h0, 5'd4, 0, 0, 32'h0);
    checkOutput("lh_misalign_latency", lastFaultCyc - lastAcceptCyc, 32'd1);
    applyStimulus(OP_LOAD, 3'b011, 32'h0000_0100, 32'h0, 5'd6, 0, 0, 32'h0);
    checkOutput("f3_011_fault_latency", lastFaultCyc - lastAcceptCyc, 32'd1);

    resetInWait(32'h0000_0040);

    applyStimulus(OP_LOAD, 3'b010, 32'h0000_0040, 32'h0, 5'd8, 0, 0, 32'h1234_5678);
    checkOutput("lw_data_literal", loaded_data, 32'h1234_5678);
    wbBefore = lastWbCyc;
    applyStimulus(OP_ADD, 3'b000, 32'h0000_00AB, 32'h0, 5'd10, 0, 0, 32'h0);
    checkOutput("back_to_back_accept", lastAcceptCyc - wbBefore, 32'd1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    op = OP_LOAD;
        2, 3:    op = OP_STORE;
        4:       op = OP_ADD;
        default: op = 7'($urandom);
      endcase
      applyStimulus(op, 3'($urandom), $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
